// File: rtl/bcd_display_mux.sv
// bcd_display_mux: time-multiplexed four-digit BCD seven-segment driver with leading-zero blanking
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [15:0] BCDIN,
  input  logic [3:0]  DPIN,
  input  logic        BLANK_EN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [3:0]  AN
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [3:0]    dpm_q, dpm_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tc, blank;
  logic [3:0]    nib;
  // Next state: slot timing, data latch, and the display word for the current slot.
  // Blanking looks at the current digit and everything above it; a non-BCD nibble is non-zero.
  always_comb begin
    tc    = cnt_q == TC;
    cnt_d = tc ? '0 : cnt_q + CW'(1);
    idx_d = tc ? idx_q + 2'd1 : idx_q;
    bcd_d = LOAD ? BCDIN : bcd_q;
    dpm_d = LOAD ? DPIN : dpm_q;
    nib   = bcd_q[{idx_q, 2'b00} +: 4];
    blank = BLANK_EN && idx_q != 2'd0 && (bcd_q >> {idx_q, 2'b00}) == 16'h0;
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : SEG_LUT[nib];
    dp_d  = ~dpm_q[idx_q];
  end
  // State and output registers; reset darks the display and clears all held data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      idx_q <= '0;
      bcd_q <= '0;
      dpm_q <= '0;
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      bcd_q <= bcd_d;
      dpm_q <= dpm_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end
  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux: random and directed checking of bcd_display_mux against a slot-time model
module tb_bcd_display_mux;
  localparam int DIV = 4;
  logic        CLK, RST, LOAD, BLANK_EN;
  logic [15:0] BCDIN;
  logic [3:0]  DPIN;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;
  int vectors = 0;
  int miscompares = 0;
  bcd_display_mux #(.REFRESH_DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .BCDIN(BCDIN), .DPIN(DPIN),
    .BLANK_EN(BLANK_EN), .SEG(SEG), .DP(DP), .AN(AN)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (n > 4'd9) ? 7'h3F : t[n];
  endfunction
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  // Model: the slot shown is (cycles since reset / DIV) mod 4, one cycle late.
  logic [3:0]  exp_an, hdp;
  logic [6:0]  exp_seg;
  logic        exp_dp, valid = 1'b0, blk;
  logic [15:0] held;
  int          ticks, k;
  always @(posedge CLK) begin
    if (RST) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      ticks = 0; held = '0; hdp = '0; valid = 1'b1;
    end else begin
      k = (ticks / DIV) % 4;
      exp_an = 4'hF;
      exp_an[k] = 1'b0;
      blk = BLANK_EN && k > 0;
      for (int j = k; j < 4; j++) if (held[4*j +: 4] != 4'd0) blk = 1'b0;
      exp_seg = blk ? 7'h7F : seg_of(held[4*k +: 4]);
      exp_dp = !hdp[k];
      ticks++;
      if (LOAD) begin held = BCDIN; hdp = DPIN; end
    end
  end
  always @(posedge CLK) begin
    #1;
    if (valid) begin
      chk("model_an", 8'(AN), 8'(exp_an));
      chk("model_seg", 8'(SEG), 8'(exp_seg));
      chk("model_dp", 8'(DP), 8'(exp_dp));
    end
  end
  task automatic ld(input logic [15:0] d, input logic [3:0] p);
    BCDIN = d; DPIN = p; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask
  task automatic wait_an(input logic [3:0] t);
    int n = 0;
    do begin @(negedge CLK); n++; end while (AN !== t && n < 40);
    if (AN !== t) chk("wait_an_timeout", 8'(AN), 8'(t));
  endtask
  initial begin
    RST = 1'b1; LOAD = 1'b0; BCDIN = '0; DPIN = '0; BLANK_EN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_rel_an", 8'(AN), 8'h0E);
    chk("rst_rel_seg", 8'(SEG), 8'h40);
    ld(16'h1234, 4'h0);
    wait_an(4'b1110); chk("d0_1234", 8'(SEG), 8'h19); chk("dp_1234", 8'(DP), 8'h01);
    wait_an(4'b1101); chk("d1_1234", 8'(SEG), 8'h30);
    wait_an(4'b1011); chk("d2_1234", 8'(SEG), 8'h24);
    wait_an(4'b0111); chk("d3_1234", 8'(SEG), 8'h79);
    BLANK_EN = 1'b1;
    ld(16'h0007, 4'h0);
    wait_an(4'b1110); chk("d0_0007", 8'(SEG), 8'h78);
    wait_an(4'b1101); chk("d1_0007_blank", 8'(SEG), 8'h7F);
    wait_an(4'b0111); chk("d3_0007_blank", 8'(SEG), 8'h7F);
    BLANK_EN = 1'b0;
    wait_an(4'b1101); chk("d1_0007_noblank", 8'(SEG), 8'h40);
    wait_an(4'b0111); chk("d3_0007_noblank", 8'(SEG), 8'h40);
    BLANK_EN = 1'b1;
    ld(16'h0000, 4'h0);
    wait_an(4'b1110); chk("d0_0000", 8'(SEG), 8'h40);
    wait_an(4'b1011); chk("d2_0000", 8'(SEG), 8'h7F);
    ld(16'h0A05, 4'h0);
    wait_an(4'b1101); chk("d1_0a05", 8'(SEG), 8'h40);
    wait_an(4'b1011); chk("d2_0a05", 8'(SEG), 8'h3F);
    wait_an(4'b0111); chk("d3_0a05", 8'(SEG), 8'h7F);
    BLANK_EN = 1'b0;
    ld(16'h9999, 4'b0100);
    wait_an(4'b1110); chk("dp_d0_9999", 8'(DP), 8'h01); chk("d0_9999", 8'(SEG), 8'h10);
    wait_an(4'b1011); chk("dp_d2_9999", 8'(DP), 8'h00); chk("d2_9999", 8'(SEG), 8'h10);
    wait_an(4'b0111); chk("dp_d3_9999", 8'(DP), 8'h01);
    wait_an(4'b1011);
    wait_an(4'b0111);
    repeat (2) @(negedge CLK);
    ld(16'h9993, 4'h0);
    chk("wrap_last_d3", 8'(AN), 8'h07);
    @(negedge CLK);
    chk("wrap_an", 8'(AN), 8'h0E);
    chk("wrap_new_d0", 8'(SEG), 8'h30);
    ld(16'h5678, 4'h0);
    wait_an(4'b1011);
    RST = 1'b1; LOAD = 1'b1; BCDIN = 16'h1111;
    @(negedge CLK);
    chk("midscan_rst_an", 8'(AN), 8'h0F);
    chk("midscan_rst_seg", 8'(SEG), 8'h7F);
    chk("midscan_rst_dp", 8'(DP), 8'h01);
    RST = 1'b0; LOAD = 1'b0;
    @(negedge CLK);
    chk("post_rst_an", 8'(AN), 8'h0E);
    chk("post_rst_seg", 8'(SEG), 8'h40);
    repeat (4) @(negedge CLK);
    chk("post_rst_next_an", 8'(AN), 8'h0D);
    chk("post_rst_next_seg", 8'(SEG), 8'h40);
    for (int i = 0; i < 600; i++) begin
      RST = $urandom_range(0, 99) == 0;
      LOAD = $urandom_range(0, 5) == 0;
      BCDIN = 16'($urandom);
      DPIN = 4'($urandom);
      if ($urandom_range(0, 30) == 0) BLANK_EN = ~BLANK_EN;
      @(negedge CLK);
    end
    RST = 1'b0; LOAD = 1'b0;
    repeat (20) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
